// File: rtl/coverfloat_vector_sequencer.sv
// coverfloat_vector_sequencer
// Walks a directed vector table, issues each vector to the FPU under test over
// a valid/ready request, waits for the response (or a timeout) and scores it.
// Every output comes straight from a register, so no input reaches an output
// combinationally.
module coverfloat_vector_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_vectors,
  input  logic [7:0]        flag_mask,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       vec_op,
  input  logic [7:0]        vec_rm,
  input  logic [7:0]        vec_fmt,
  input  logic [127:0]      vec_a,
  input  logic [127:0]      vec_b,
  input  logic [127:0]      vec_c,
  input  logic [127:0]      vec_exp_result,
  input  logic [7:0]        vec_exp_flags,
  output logic              dut_req_valid,
  input  logic              dut_req_ready,
  output logic [31:0]       dut_op,
  output logic [7:0]        dut_rm,
  output logic [7:0]        dut_fmt,
  output logic [127:0]      dut_a,
  output logic [127:0]      dut_b,
  output logic [127:0]      dut_c,
  input  logic              dut_rsp_valid,
  input  logic [127:0]      dut_rsp_result,
  input  logic [7:0]        dut_rsp_flags,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pass_count,
  output logic [ADDR_W-1:0] fail_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              any_fail,
  output logic              timeout_err,
  output logic              spurious_rsp
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LOAD     = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_RSP = 3'd4,
    S_CHECK    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [15:0] TMO_C = 16'(TIMEOUT);

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   nv_q;
  logic [7:0]          mask_q;
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         op_q;
  logic [7:0]          rm_q;
  logic [7:0]          fmt_q;
  logic [127:0]        a_q;
  logic [127:0]        b_q;
  logic [127:0]        c_q;
  logic [127:0]        exp_res_q;
  logic [7:0]          exp_flags_q;
  logic                req_valid_q;
  logic [127:0]        rsp_res_q;
  logic [7:0]          rsp_flags_q;
  logic [15:0]         tmo_q;
  logic [ADDR_W-1:0]   pass_q;
  logic [ADDR_W-1:0]   fail_q;
  logic [ADDR_W-1:0]   ffi_q;
  logic                any_fail_q;
  logic                timeout_err_q;
  logic                spurious_q;
  logic                done_q;

  logic [ADDR_W:0]     idx_p1_d;
  logic                last_vec_d;
  logic [ADDR_W-1:0]   idx_inc_d;
  logic [ADDR_W-1:0]   pass_inc_d;
  logic [ADDR_W-1:0]   fail_inc_d;
  logic [15:0]         tmo_inc_d;
  logic                tmo_hit_d;
  logic                check_pass_d;

  // Shared next-value helpers: end-of-run detect, saturating bumps, verdict.
  always_comb begin
    idx_p1_d     = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
    last_vec_d   = (idx_p1_d == {1'b0, nv_q});
    idx_inc_d    = sat_inc(idx_q);
    pass_inc_d   = sat_inc(pass_q);
    fail_inc_d   = sat_inc(fail_q);
    tmo_inc_d    = tmo_q + 16'd1;
    tmo_hit_d    = (tmo_inc_d == TMO_C);
    check_pass_d = (rsp_res_q == exp_res_q) &&
                   ((rsp_flags_q & mask_q) == (exp_flags_q & mask_q));
  end

  // Sequencer FSM with all datapath and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      nv_q          <= '0;
      mask_q        <= 8'h00;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      op_q          <= 32'h0;
      rm_q          <= 8'h00;
      fmt_q         <= 8'h00;
      a_q           <= 128'h0;
      b_q           <= 128'h0;
      c_q           <= 128'h0;
      exp_res_q     <= 128'h0;
      exp_flags_q   <= 8'h00;
      req_valid_q   <= 1'b0;
      rsp_res_q     <= 128'h0;
      rsp_flags_q   <= 8'h00;
      tmo_q         <= 16'h0;
      pass_q        <= '0;
      fail_q        <= '0;
      ffi_q         <= '0;
      any_fail_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      spurious_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;
      // A response is only expected while waiting; anything else is flagged.
      if (dut_rsp_valid && (state_q != S_WAIT_RSP)) begin
        spurious_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q         <= '0;
            nv_q          <= num_vectors;
            mask_q        <= flag_mask;
            pass_q        <= '0;
            fail_q        <= '0;
            ffi_q         <= '0;
            any_fail_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            spurious_q    <= 1'b0;
            if (num_vectors == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= '0;
            end
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          op_q        <= vec_op;
          rm_q        <= vec_rm;
          fmt_q       <= vec_fmt;
          a_q         <= vec_a;
          b_q         <= vec_b;
          c_q         <= vec_c;
          exp_res_q   <= vec_exp_result;
          exp_flags_q <= vec_exp_flags;
          req_valid_q <= 1'b1;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (dut_req_ready) begin
            req_valid_q <= 1'b0;
            tmo_q       <= 16'h0;
            state_q     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (dut_rsp_valid) begin
            rsp_res_q   <= dut_rsp_result;
            rsp_flags_q <= dut_rsp_flags;
            state_q     <= S_CHECK;
          end else if (tmo_hit_d) begin
            timeout_err_q <= 1'b1;
            fail_q        <= fail_inc_d;
            if (!any_fail_q) begin
              any_fail_q <= 1'b1;
              ffi_q      <= idx_q;
            end
            idx_q <= idx_inc_d;
            if (last_vec_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= idx_inc_d;
            end
          end else begin
            tmo_q <= tmo_inc_d;
          end
        end
        S_CHECK: begin
          if (check_pass_d) begin
            pass_q <= pass_inc_d;
          end else begin
            fail_q <= fail_inc_d;
            if (!any_fail_q) begin
              any_fail_q <= 1'b1;
              ffi_q      <= idx_q;
            end
          end
          idx_q <= idx_inc_d;
          if (last_vec_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= idx_inc_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd         = mem_rd_q;
  assign mem_addr       = mem_addr_q;
  assign dut_req_valid  = req_valid_q;
  assign dut_op         = op_q;
  assign dut_rm         = rm_q;
  assign dut_fmt        = fmt_q;
  assign dut_a          = a_q;
  assign dut_b          = b_q;
  assign dut_c          = c_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = ffi_q;
  assign any_fail       = any_fail_q;
  assign timeout_err    = timeout_err_q;
  assign spurious_rsp   = spurious_q;

endmodule
